// File: rtl/fifo_rd_stream.sv
// Read-side front end for the synchronous FIFO: hides the one-cycle read latency and
// presents the words as a valid/ready stream through a 3-entry output buffer.
module fifo_rd_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rd_enable,
  input  logic             i_fifo_empty,
  input  logic [WIDTH-1:0] i_fifo_rd_data,
  output logic             o_fifo_rd_en,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [WIDTH-1:0] o_m_data,
  output logic [1:0]       o_buf_level,
  output logic [CNT_W-1:0] o_word_cnt
);

  localparam int Depth = 3;

  logic [WIDTH-1:0] r_mem [Depth];
  logic [1:0]       r_head;
  logic [1:0]       r_tail;
  logic [1:0]       r_occ;
  logic             r_pend;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_xfer;
  logic [2:0]       w_committed;
  logic             w_credit;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts the in-flight word, so a new read is issued only when its data is
  // guaranteed a free slot; m_ready is deliberately kept out of this path.
  always_comb begin
    w_committed = {1'b0, r_occ} + {2'b00, r_pend};
    w_credit    = (w_committed < 3'd3);
  end

  assign o_fifo_rd_en = i_rd_enable & ~i_fifo_empty & ~i_rst & w_credit;
  assign o_m_valid    = (r_occ != 2'd0);
  assign o_m_data     = r_mem[r_head];
  assign o_buf_level  = r_occ;
  assign o_word_cnt   = r_word_cnt;
  assign w_xfer       = o_m_valid & i_m_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      r_occ      <= 2'd0;
      r_pend     <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_pend <= o_fifo_rd_en;
      if (r_pend) begin
        r_mem[r_tail] <= i_fifo_rd_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_xfer) begin
        r_head     <= ptr_inc(r_head);
        r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case ({r_pend, w_xfer})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  a_no_capture_when_full : assert property (
    @(posedge i_clk) disable iff (i_rst) r_pend |-> (r_occ != 2'd3));

  a_no_read_when_empty : assert property (
    @(posedge i_clk) disable iff (i_rst) o_fifo_rd_en |-> !i_fifo_empty);

  a_hold_while_stalled : assert property (
    @(posedge i_clk) disable iff (i_rst)
    (o_m_valid && !i_m_ready) |=> (o_m_valid && $stable(o_m_data)));

endmodule
